mips_dmem_block_mover: RTL

//  Bus initiator for the data memory. Drives its write-enable, address and

---
 rtl/mips_dmem_block_mover.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_dmem_block_mover.sv
// -----------------------------------------------------------------------------
// mips_dmem_block_mover
//   Bus initiator for the data memory. Performs word-addressed block copy
//   (src..src+len-1 -> dst..dst+len-1, ascending, forward-memcpy semantics)
//   and block fill (dst..dst+len-1 <= fill_value). The core regains the
//   memory port through an external mux whenever busy_o is low.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous reset, active-high
//   start_i        start request, only honoured in IDLE
//   mode_i         0 = copy, 1 = fill
//   src_addr_i     copy source base word address
//   dst_addr_i     destination base word address
//   len_i          number of words to transfer
//   fill_value_i   data written in fill mode
//   mem_rd_i       memory read data, combinational on mem_a_o
//   mem_we_o       memory write enable
//   mem_a_o        memory word address
//   mem_wd_o       memory write data
//   busy_o         high in RD and WR
//   done_o         one-cycle completion pulse (DONE state)
//   err_o          range error, held until the next accepted start
//   words_done_o   words written in the current or last operation
// -----------------------------------------------------------------------------
module mips_dmem_block_mover #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] src_addr_i,
  input  logic [WIDTH-1:0] dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [WIDTH-1:0] fill_value_i,
  input  logic [WIDTH-1:0] mem_rd_i,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic [WIDTH-1:0] mem_wd_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Range checks use one extra bit so base+len cannot wrap past DEPTH.
  localparam logic [WIDTH:0]   DEPTH_X = (WIDTH+1)'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ZERO_L  = {LEN_W{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] words_q, words_d;

  logic [WIDTH:0]   len_ext_s;
  logic [WIDTH:0]   dst_end_s;
  logic [WIDTH:0]   src_end_s;
  logic             len_zero_s;
  logic             range_bad_s;
  logic [WIDTH-1:0] idx_ext_s;
  logic             last_s;

  assign len_ext_s   = {{(WIDTH+1-LEN_W){1'b0}}, len_i};
  assign dst_end_s   = {1'b0, dst_addr_i} + len_ext_s;
  assign src_end_s   = {1'b0, src_addr_i} + len_ext_s;
  assign len_zero_s  = (len_i == ZERO_L);
  // The source range only matters for copy.
  assign range_bad_s = (dst_end_s > DEPTH_X) || (!mode_i && (src_end_s > DEPTH_X));
  assign idx_ext_s   = {{(WIDTH-LEN_W){1'b0}}, idx_q};
  assign last_s      = ((idx_q + ONE_L) == len_q);

  assign err_o        = err_q;
  assign words_done_o = words_q;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= ZERO_W;
      dst_q   <= ZERO_W;
      len_q   <= ZERO_L;
      fill_q  <= ZERO_W;
      idx_q   <= ZERO_L;
      data_q  <= ZERO_W;
      err_q   <= 1'b0;
      words_q <= ZERO_L;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_zero_s || range_bad_s) begin
            state_d = S_DONE;
          end else begin
            state_d = mode_i ? S_WR : S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:   state_d = S_WR;
      S_WR: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = mode_q ? S_WR : S_RD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch request on accept, capture read data, advance index.
  always_comb begin
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    words_d = words_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_i;
          fill_d  = fill_value_i;
          idx_d   = ZERO_L;
          words_d = ZERO_L;
          // An empty transfer is never an error, whatever the addresses.
          err_d   = !len_zero_s && range_bad_s;
        end else begin
          err_d   = err_q;
        end
      end
      S_RD:   data_d = mem_rd_i;
      S_WR: begin
        idx_d   = idx_q + ONE_L;
        words_d = words_q + ONE_L;
      end
      S_DONE: idx_d = idx_q;
      default: idx_d = idx_q;
    endcase
  end

  // Moore output decode: memory port and status strobes from state and registers.
  always_comb begin
    mem_we_o = 1'b0;
    mem_a_o  = ZERO_W;
    mem_wd_o = ZERO_W;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      S_IDLE: busy_o = 1'b0;
      S_RD: begin
        mem_a_o = src_q + idx_ext_s;
        busy_o  = 1'b1;
      end
      S_WR: begin
        mem_a_o  = dst_q + idx_ext_s;
        mem_we_o = 1'b1;
        mem_wd_o = mode_q ? fill_q : data_q;
        busy_o   = 1'b1;
      end
      S_DONE: done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

endmodule
